priv_1_12_trap_ctrl: RTL and testbench
======================================

Name: priv_1_12_trap_ctrl

Overview:
Machine-mode trap sequencer for the v1.12 privileged unit. Prioritises pending exceptions and interrupts, drains the pipeline, and commits mepc/mcause/mtval/mstatus updates in a fixed order. Redirects fetch to the mtvec target on trap entry and to mepc on mret. It sits between the pipeline-facing privileged interface and the M-mode CSR file, and is the only writer of the trap CSRs.

Parameters:
XLEN, 32, datapath and CSR width
FLUSH_TIMEOUT, 15, maximum cycles to wait for pipe_idle before forcing the commit; 4-bit counter

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ex_vec  in  12  exception requests, bit i = mcause code i (bits 0-7, 11 used; 8-10 ignored)
ex_pc  in  XLEN  PC of the faulting instruction
ex_tval  in  XLEN  bad address or instruction bits for the exception
irq_pend  in  3  {mei, mti, msi} pending, already ANDed with mie
mstatus_mie  in  1  global interrupt enable
mtvec  in  XLEN  [1:0] = mode (0 direct, 1 vectored), [XLEN-1:2] = base
mepc_in  in  XLEN  current mepc
wb_pc  in  XLEN  PC of the next instruction to retire (epc for interrupts)
mret_req  in  1  mret in writeback
pipe_idle  in  1  pipeline drained after flush
flush  out  1  squash all in-flight instructions
csr_we  out  1  single-cycle trap CSR commit strobe
mepc_out  out  XLEN  value for mepc
mcause_out  out  XLEN  {interrupt bit, code}
mtval_out  out  XLEN  value for mtval
mie_we  out  1  strobe to update mstatus.MIE/MPIE
mie_next  out  1  new MIE
mpie_next  out  1  new MPIE
redirect  out  1  one-cycle PC insert
redirect_pc  out  XLEN  target PC
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; latched cause, epc, tval, and timeout counter = 0.
- States: IDLE, FLUSH, COMMIT, REDIRECT, RET.
- IDLE, when any ex_vec bit is set:
  - Latch the highest-priority code in this order: 1, 2, 0, 3, 11, 6, 4, 7, 5.
  - Latch epc = ex_pc, tval = ex_tval, interrupt bit = 0.
  - Go to FLUSH.
- IDLE, else if mstatus_mie and irq_pend is nonzero:
  - Latch code in priority order mei = 11, msi = 3, mti = 7.
  - Latch epc = wb_pc, tval = 0, interrupt bit = 1.
  - Go to FLUSH.
- IDLE, else if mret_req: go to RET.
- Simultaneous events: exception beats interrupt, which beats mret. Requests that arrive while busy are ignored; callers hold them.
- FLUSH:
  - flush = 1 every cycle in this state.
  - Timeout counter increments each cycle.
  - Go to COMMIT when pipe_idle = 1 or the counter reaches FLUSH_TIMEOUT.
  - Minimum residency is 1 cycle.
- COMMIT (exactly 1 cycle):
  - csr_we = 1 and mie_we = 1.
  - mepc_out = epc with bits [1:0] forced to 0.
  - mcause_out = {intr, zero-extended code}.
  - mtval_out = tval.
  - mpie_next = mstatus_mie, mie_next = 0.
  - Go to REDIRECT.
- REDIRECT (1 cycle):
  - redirect = 1.
  - redirect_pc = {base, 2'b00}, or for a vectored interrupt {base, 2'b00} + 4*code. Addition is modulo 2^XLEN.
  - Clear the timeout counter and go to IDLE.
- RET (1 cycle):
  - flush = 1, mie_we = 1, mie_next = mstatus MPIE as latched, mpie_next = 1.
  - redirect = 1, redirect_pc = mepc_in with bits [1:0] = 0.
  - Go to IDLE.
  - MPIE is not a port; the block tracks it internally. A shadow register is written at COMMIT and set to 1 at RET.
- Trap latency: entry to redirect is at least 3 cycles (FLUSH, COMMIT, REDIRECT). mret is 1 cycle.
- All outputs are registered-state decodes; none are combinational from inputs.
- Reset mid-sequence returns to IDLE immediately and drops all strobes asynchronously.
- busy = (state != IDLE).

Test Plan:
- Illegal instruction: ex_vec = 0x004, ex_pc = 0x80000100, ex_tval = 0xDEADBEEF, pipe_idle high -> mcause = 0x2, mepc = 0x80000100, mtval = 0xDEADBEEF, redirect_pc = mtvec base. Redirect occurs 3 cycles after the request.
- Priority: ex_vec = 0x809 (codes 0, 3, 11) -> mcause = 0x0. ex_vec = 0x0A0 (codes 5, 7) -> mcause = 0x7.
- Vectored interrupt: mtvec = 0x00001001, irq_pend = {mei=1, mti=1, msi=0}, mie = 1 -> mcause = 0x8000000B, redirect_pc = 0x0000102C, mepc = wb_pc, mpie_next = 1, mie_next = 0.
- Interrupt masked: mstatus_mie = 0 with irq_pend = 3'b111 -> FSM stays IDLE, no strobes for 20 cycles. An mret_req asserted in the same window produces a 1-cycle RET with redirect_pc = mepc_in & ~3.
- Flush timeout: pipe_idle held 0 -> flush is asserted for exactly 15 cycles, then COMMIT. A second exception during FLUSH is ignored.
- Asynchronous reset: nRST pulsed low in COMMIT -> csr_we and redirect are 0 at once, busy = 0, and no redirect follows once reset releases.

Source files
------------

// File: rtl/priv_1_12_trap_ctrl.sv
// Machine-mode trap sequencer: prioritises exceptions/interrupts, drains the
// pipe, commits mepc/mcause/mtval/mstatus, and redirects fetch (trap or mret).
//
// Ports:
//   CLK, nRST                    clock, async active-low reset
//   ex_vec, ex_pc, ex_tval       exception requests and their pc/tval
//   irq_pend, mstatus_mie        {mei,mti,msi} pending (pre-masked), global MIE
//   mtvec, mepc_in, wb_pc        trap vector, current mepc, next-retire pc
//   mret_req, pipe_idle          mret in writeback, pipeline drained
//   flush                        squash in-flight instructions
//   csr_we, mepc_out,
//   mcause_out, mtval_out        trap CSR commit strobe and values
//   mie_we, mie_next, mpie_next  mstatus.MIE/MPIE update
//   redirect, redirect_pc        one-cycle fetch redirect
//   busy                         sequencer not idle
module priv_1_12_trap_ctrl #(
   parameter int XLEN          = 32,
   parameter int FLUSH_TIMEOUT = 15
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic [11:0]     ex_vec,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_tval,
   input  logic [2:0]      irq_pend,
   input  logic            mstatus_mie,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc_in,
   input  logic [XLEN-1:0] wb_pc,
   input  logic            mret_req,
   input  logic            pipe_idle,
   output logic            flush,
   output logic            csr_we,
   output logic [XLEN-1:0] mepc_out,
   output logic [XLEN-1:0] mcause_out,
   output logic [XLEN-1:0] mtval_out,
   output logic            mie_we,
   output logic            mie_next,
   output logic            mpie_next,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_COMMIT,
      S_REDIRECT,
      S_RET
   } state_t;

   localparam logic [3:0] LP_TO = 4'(FLUSH_TIMEOUT);

   state_t          r_state;
   state_t          w_next;
   logic [3:0]      r_code;
   logic            r_intr;
   logic [XLEN-1:0] r_epc;
   logic [XLEN-1:0] r_tval;
   logic [XLEN-1:0] r_tvec;
   logic [XLEN-1:0] r_ret_pc;
   logic            r_mie_snap;
   logic            r_mpie;
   logic [3:0]      r_cnt;

   logic [3:0]      w_ex_code;
   logic [3:0]      w_irq_code;
   logic            w_ex_any;
   logic            w_irq_take;
   logic [3:0]      w_cnt_inc;
   logic            w_flush_done;
   logic [XLEN-1:0] w_tvec_base;
   logic [XLEN-1:0] w_vec_off;
   logic            w_unused;

   // codes 8-10 are not M-mode causes handled here
   assign w_ex_any     = |(ex_vec & 12'h8FF);
   assign w_irq_take   = mstatus_mie && (|irq_pend);
   assign w_cnt_inc    = r_cnt + 4'd1;
   assign w_flush_done = pipe_idle || (w_cnt_inc == LP_TO);
   assign w_unused     = ^{ex_vec[10:8], r_epc[1:0], r_ret_pc[1:0]};

   // architectural exception priority: 1,2,0,3,11,6,4,7,5
   always_comb begin
      w_ex_code = 4'd0;
      if      (ex_vec[1])  w_ex_code = 4'd1;
      else if (ex_vec[2])  w_ex_code = 4'd2;
      else if (ex_vec[0])  w_ex_code = 4'd0;
      else if (ex_vec[3])  w_ex_code = 4'd3;
      else if (ex_vec[11]) w_ex_code = 4'd11;
      else if (ex_vec[6])  w_ex_code = 4'd6;
      else if (ex_vec[4])  w_ex_code = 4'd4;
      else if (ex_vec[7])  w_ex_code = 4'd7;
      else if (ex_vec[5])  w_ex_code = 4'd5;
   end

   // irq_pend = {mei, mti, msi}; priority mei > msi > mti
   always_comb begin
      w_irq_code = 4'd7;
      if      (irq_pend[2]) w_irq_code = 4'd11;
      else if (irq_pend[0]) w_irq_code = 4'd3;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if      (w_ex_any)   w_next = S_FLUSH;
            else if (w_irq_take) w_next = S_FLUSH;
            else if (mret_req)   w_next = S_RET;
         end
         S_FLUSH:    if (w_flush_done) w_next = S_COMMIT;
         S_COMMIT:   w_next = S_REDIRECT;
         S_REDIRECT: w_next = S_IDLE;
         S_RET:      w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // trap context; inputs consumed later are snapshotted so every
   // output is a pure decode of registered state
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_code     <= '0;
         r_intr     <= 1'b0;
         r_epc      <= '0;
         r_tval     <= '0;
         r_tvec     <= '0;
         r_ret_pc   <= '0;
         r_mie_snap <= 1'b0;
         r_mpie     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_ex_any) begin
                  r_code <= w_ex_code;
                  r_intr <= 1'b0;
                  r_epc  <= ex_pc;
                  r_tval <= ex_tval;
               end else if (w_irq_take) begin
                  r_code <= w_irq_code;
                  r_intr <= 1'b1;
                  r_epc  <= wb_pc;
                  r_tval <= '0;
               end else if (mret_req) begin
                  r_ret_pc <= mepc_in;
               end
            end
            S_FLUSH: begin
               r_cnt <= w_cnt_inc;
               if (w_flush_done) begin
                  r_tvec     <= mtvec;
                  r_mie_snap <= mstatus_mie;
               end
            end
            S_COMMIT:   r_mpie <= r_mie_snap;
            S_REDIRECT: r_cnt  <= '0;
            S_RET:      r_mpie <= 1'b1;
            default: ;
         endcase
      end
   end

   assign w_tvec_base = {r_tvec[XLEN-1:2], 2'b00};
   assign w_vec_off   = (r_intr && r_tvec[1:0] == 2'b01) ?
                        {{(XLEN-6){1'b0}}, r_code, 2'b00} : '0;

   always_comb begin
      flush       = 1'b0;
      csr_we      = 1'b0;
      mepc_out    = '0;
      mcause_out  = '0;
      mtval_out   = '0;
      mie_we      = 1'b0;
      mie_next    = 1'b0;
      mpie_next   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      busy        = (r_state != S_IDLE);
      unique case (r_state)
         S_FLUSH: flush = 1'b1;
         S_COMMIT: begin
            csr_we     = 1'b1;
            mie_we     = 1'b1;
            mepc_out   = {r_epc[XLEN-1:2], 2'b00};
            mcause_out = {r_intr, {(XLEN-5){1'b0}}, r_code};
            mtval_out  = r_tval;
            mpie_next  = r_mie_snap;
         end
         S_REDIRECT: begin
            redirect    = 1'b1;
            redirect_pc = w_tvec_base + w_vec_off;
         end
         S_RET: begin
            flush       = 1'b1;
            mie_we      = 1'b1;
            mie_next    = r_mpie;
            mpie_next   = 1'b1;
            redirect    = 1'b1;
            redirect_pc = {r_ret_pc[XLEN-1:2], 2'b00};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_priv_1_12_trap_ctrl.sv
// Bench for priv_1_12_trap_ctrl: directed and random traps/mrets compared
// against a cause-priority/vector reference model.
module tb_priv_1_12_trap_ctrl;
   localparam int XLEN = 32;

   logic            CLK = 1'b0;
   logic            nRST = 1'b1;
   logic [11:0]     ex_vec = '0;
   logic [XLEN-1:0] ex_pc = '0;
   logic [XLEN-1:0] ex_tval = '0;
   logic [2:0]      irq_pend = '0;
   logic            mstatus_mie = 1'b0;
   logic [XLEN-1:0] mtvec = '0;
   logic [XLEN-1:0] mepc_in = '0;
   logic [XLEN-1:0] wb_pc = '0;
   logic            mret_req = 1'b0;
   logic            pipe_idle = 1'b0;
   logic            flush, csr_we, mie_we, mie_next, mpie_next;
   logic            redirect, busy;
   logic [XLEN-1:0] mepc_out, mcause_out, mtval_out, redirect_pc;

   int total = 0;
   int bad = 0;
   bit model_mpie = 1'b0;

   always #5 CLK = ~CLK;

   priv_1_12_trap_ctrl #(.XLEN(XLEN), .FLUSH_TIMEOUT(15)) dut (
      .CLK(CLK), .nRST(nRST), .ex_vec(ex_vec), .ex_pc(ex_pc),
      .ex_tval(ex_tval), .irq_pend(irq_pend), .mstatus_mie(mstatus_mie),
      .mtvec(mtvec), .mepc_in(mepc_in), .wb_pc(wb_pc),
      .mret_req(mret_req), .pipe_idle(pipe_idle), .flush(flush),
      .csr_we(csr_we), .mepc_out(mepc_out), .mcause_out(mcause_out),
      .mtval_out(mtval_out), .mie_we(mie_we), .mie_next(mie_next),
      .mpie_next(mpie_next), .redirect(redirect),
      .redirect_pc(redirect_pc), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // cause/epc/tval/target derived straight from the architectural rules
   function automatic void ref_trap(
      input  logic [11:0] ex, input logic [2:0] irq,
      input  logic [31:0] pc, input logic [31:0] tval,
      input  logic [31:0] wbpc, input logic [31:0] tvec,
      output logic [31:0] cause, output logic [31:0] epc,
      output logic [31:0] tv, output logic [31:0] tgt);
      int ord[9] = '{1, 2, 0, 3, 11, 6, 4, 7, 5};
      int code = -1;
      bit intr = 1'b0;
      foreach (ord[k]) if (code < 0 && ex[ord[k]]) code = ord[k];
      if (code < 0) begin
         intr = 1'b1;
         code = irq[2] ? 11 : (irq[0] ? 3 : 7);
      end
      cause = {intr, 31'(code)};
      epc = intr ? wbpc : pc;
      epc = epc & ~32'h3;
      tv = intr ? 32'h0 : tval;
      tgt = tvec & ~32'h3;
      if (intr && tvec[1:0] == 2'b01) tgt = tgt + 32'(4 * code);
   endfunction

   // called at a negedge; drives a request and follows the whole sequence
   task automatic do_trap(input string tag, input logic [11:0] ex,
      input logic [2:0] irq, input logic mie, input logic [31:0] tvec,
      input logic [31:0] pc, input logic [31:0] tval,
      input logic [31:0] wbpc, input int d, input bit poke,
      input bit mret);
      logic [31:0] ec, ee, et, eg;
      int nfl, cw, rd, ef;
      bit done;
      nfl = 0; cw = -1; rd = -1; done = 1'b0;
      ref_trap(ex, irq, pc, tval, wbpc, tvec, ec, ee, et, eg);
      ef = (d < 15) ? d : 15;
      ex_vec = ex; irq_pend = irq; mstatus_mie = mie; mtvec = tvec;
      ex_pc = pc; ex_tval = tval; wb_pc = wbpc; pipe_idle = 1'b0;
      mret_req = mret;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge CLK);
         if (c == 1) begin
            ex_vec = '0; irq_pend = '0; mret_req = 1'b0;
         end
         if (poke && c == 3) ex_vec = 12'h001;
         if (poke && c == 4) ex_vec = '0;
         if (flush) begin
            nfl++;
            pipe_idle = (nfl >= d);
         end
         if (csr_we) begin
            cw = c;
            chk({tag, " mepc"}, mepc_out, ee);
            chk({tag, " mcause"}, mcause_out, ec);
            chk({tag, " mtval"}, mtval_out, et);
            chk({tag, " mie_we"}, 32'(mie_we), 32'd1);
            chk({tag, " mie_next"}, 32'(mie_next), 32'd0);
            chk({tag, " mpie_next"}, 32'(mpie_next), 32'(mie));
            model_mpie = mie;
         end
         if (redirect) begin
            rd = c;
            chk({tag, " redirect_pc"}, redirect_pc, eg);
         end
         if (!busy) done = 1'b1;
      end
      pipe_idle = 1'b0;
      chk({tag, " flush_cycles"}, 32'(nfl), 32'(ef));
      chk({tag, " commit_cycle"}, 32'(cw), 32'(ef + 1));
      chk({tag, " redirect_cycle"}, 32'(rd), 32'(ef + 2));
      chk({tag, " back_idle"}, 32'(done), 32'd1);
   endtask

   task automatic do_mret(input string tag, input logic [31:0] mp);
      mepc_in = mp;
      mret_req = 1'b1;
      @(negedge CLK);
      mret_req = 1'b0;
      chk({tag, " flush"}, 32'(flush), 32'd1);
      chk({tag, " mie_we"}, 32'(mie_we), 32'd1);
      chk({tag, " mie_next"}, 32'(mie_next), 32'(model_mpie));
      chk({tag, " mpie_next"}, 32'(mpie_next), 32'd1);
      chk({tag, " redirect"}, 32'(redirect), 32'd1);
      chk({tag, " redirect_pc"}, redirect_pc, mp & ~32'h3);
      chk({tag, " csr_we"}, 32'(csr_we), 32'd0);
      @(negedge CLK);
      chk({tag, " done"}, 32'({busy, redirect, flush}), 32'd0);
      model_mpie = 1'b1;
   endtask

   initial begin
      int kind, d, bitn;
      logic [31:0] r, tv;
      logic [11:0] e;
      logic [2:0] ir;
      bit mie, mr;

      #1 nRST = 1'b0;
      #2;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst strobes", 32'({flush, csr_we, mie_we, mie_next, mpie_next,
                              redirect}), 32'd0);
      chk("rst mcause", mcause_out, 32'd0);
      chk("rst redirect_pc", redirect_pc, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);

      do_trap("illegal", 12'h004, 3'b000, 1'b1, 32'h0000_2000,
              32'h8000_0100, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 1'b0);
      do_trap("prio809", 12'h809, 3'b000, 1'b1, 32'h0000_3001,
              32'h8000_0204, 32'h1234_5678, 32'h0, 1, 1'b0, 1'b0);
      do_trap("prio0A0", 12'h0A0, 3'b000, 1'b0, 32'h0000_3000,
              32'h8000_0306, 32'h0000_0044, 32'h0, 2, 1'b0, 1'b0);
      do_trap("vec_irq", 12'h000, 3'b110, 1'b1, 32'h0000_1001,
              32'h0, 32'hFFFF_FFFF, 32'h8000_0440, 1, 1'b0, 1'b0);

      irq_pend = 3'b111;
      mstatus_mie = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         chk("masked idle", 32'({busy, csr_we, redirect, flush, mie_we}),
             32'd0);
      end
      do_mret("masked_mret", 32'h8000_0443);
      irq_pend = '0;

      do_trap("timeout", 12'h008, 3'b000, 1'b0, 32'h0000_4000,
              32'h8000_0500, 32'h0000_0000, 32'h0, 20, 1'b1, 1'b0);
      do_mret("mret_mpie0", 32'h8000_0504);

      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(0, 2);
         r = $urandom;
         tv = {r[31:2], 1'b0, 1'($urandom_range(0, 1))};
         d = $urandom_range(1, 18);
         mie = 1'($urandom_range(0, 1));
         if (kind == 0) begin
            e = 12'($urandom);
            if ((e & 12'h8FF) == 12'h0) begin
               bitn = $urandom_range(0, 7);
               e[bitn] = 1'b1;
            end
            ir = 3'($urandom);
            mr = 1'($urandom_range(0, 1));
            do_trap("rnd_exc", e, ir, mie, tv, $urandom, $urandom,
                    $urandom, d, 1'b0, mr);
         end else if (kind == 1) begin
            ir = 3'($urandom_range(1, 7));
            do_trap("rnd_irq", 12'h000, ir, 1'b1, tv, $urandom, $urandom,
                    $urandom, d, 1'b0, 1'b0);
         end else begin
            do_mret("rnd_mret", $urandom);
         end
      end

      ex_vec = 12'h004; ex_pc = 32'h8000_0600; ex_tval = 32'h1;
      mtvec = 32'h0000_5000; mstatus_mie = 1'b1; pipe_idle = 1'b1;
      @(negedge CLK);
      ex_vec = '0;
      chk("arst flush", 32'(flush), 32'd1);
      @(negedge CLK);
      chk("arst commit", 32'(csr_we), 32'd1);
      #1 nRST = 1'b0;
      #1;
      chk("arst csr_we", 32'(csr_we), 32'd0);
      chk("arst redirect", 32'(redirect), 32'd0);
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst mie_we", 32'(mie_we), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("arst after", 32'({busy, redirect, csr_we}), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
